dec_req_scheduler: RTL and testbench
====================================

# dec_req_scheduler

Sequencing front end for the `dec_to_bin` digit encoder. It turns up to seven independent digit request lines into a stream of single, acknowledged binary digit codes. Each request line is edge-detected and the event is latched as pending. Pending digits are granted one at a time by a round-robin (or, optionally, fixed-priority) arbiter. The granted digit number is presented on `o_b` with a valid/ack handshake. The block sits between raw digit sources (keys, status strobes) and any consumer that needs one code at a time without losing simultaneous events.

## Interface
- `N_REQ`, 7, number of request lines; legal 1..15; digit k is input bit k-1.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous active-low reset.
- `i_d`  input  N_REQ  request lines; bit k-1 = digit k; level inputs, synchronous to `clk`.
- `i_ack`  input  1  consumer accepts the current code; sampled only while `o_valid`=1.
- `o_valid`  output  1  `o_b` holds a granted digit.
- `o_b`  output  4  granted digit number (1..N_REQ); 0 when `o_valid`=0.
- `o_pending`  output  N_REQ  registered pending-event vector.

## Operation
- Edge detect: `i_d_q` <= `i_d` every edge. rise = `i_d` & ~`i_d_q`. A line held high produces exactly one event.
- Pending: `pending` <= (`pending` & ~clr) | rise.
  - clr is the one-hot of the digit granted this edge.
  - Set wins over clear on the same bit, so a new event is never lost.
  - Repeated rises of a bit already pending collapse into one event.
- FSM, 2 states, reset to IDLE:
  - IDLE: if `pending`!=0, select the winner, load `o_b`=index+1, set `o_valid`=1, clear that pending bit, update `ptr`=index, go to HOLD. Otherwise stay in IDLE with `o_b`=0.
  - HOLD: `o_valid`, `o_b` stable. If `i_ack`=1, then `o_valid`<=0, `o_b`<=0, go to IDLE. Otherwise stay.
- Round-robin selection: search `pending` starting at `ptr`+1, wrapping modulo N_REQ. The first set bit wins. `ptr` resets to N_REQ-1, so digit 1 has priority first.
- Only `pending` is used for selection. Events arriving during HOLD accumulate.
- Reset values: `o_valid`=0, `o_b`=0, `o_pending`=0, `i_d_q`=0, `ptr`=N_REQ-1, state IDLE.
  - Because `i_d_q` resets to 0, a line held high across reset release yields one event on the first edge after release.
- Reset mid-HOLD or with pending events: everything is discarded, with no partial grant.

## Timing
- Latency: `i_d` high before edge E sets pending at E. `o_valid`=1 and `o_b` are valid after edge E+1.
- The handshake completes on the edge where `o_valid`=1 and `i_ack`=1. `o_valid` is low for at least one cycle (the IDLE cycle) between consecutive grants.
- Maximum throughput: one grant per 2 cycles with `i_ack` tied high.
- All outputs are registered. There are no combinational paths from `i_d` or `i_ack` to outputs.

## Configuration
- `DEC_SCHED_FIXED_PRIO_EN` defined: fixed priority, where the highest pending digit always wins. This matches `dec_to_bin` priority. `ptr` is not implemented, and low digits may starve.
- Undefined (default): round-robin as above, and each pending digit is granted within N_REQ grants.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `i_d`=7'h00 -> `o_valid`=0, `o_b`=0, `o_pending`=0. Release -> no grant.
- Single event: `i_d`=7'b0000001 for 1 cycle, `i_ack`=1 -> `o_valid` high for exactly 1 cycle, 2 edges later, with `o_b`=1. `o_pending` then reads 0.
- Simultaneous: digits 3, 5, 7 rise on the same cycle, `i_ack` given 3 cycles after each `o_valid`.
  - Round-robin: grants 3, 5, 7.
  - With `DEC_SCHED_FIXED_PRIO_EN`: grants 7, 5, 3.
  - `o_valid` low at least 1 cycle between grants.
- Stall/no retrigger: digit 5 rises and is held high, `i_ack`=0 for 10 cycles -> `o_valid`=1 and `o_b`=5 stable. After `i_ack`, no second grant while digit 5 stays high.
- Fairness: digits 2 and 6 re-pulse after every grant, `i_ack`=1.
  - Round-robin: sequence 2, 6, 2, 6.
  - Fixed priority: 6 repeatedly.
- Reset mid-operation: in HOLD with `o_b`=4 and digit 1 pending, pulse `rst_n`=0 for 1 cycle with `i_d`=0 -> `o_valid`=0, `o_b`=0, `o_pending`=0, and no later grant.

Source files
------------

// File: rtl/dec_req_scheduler.sv
// Edge-detecting request scheduler feeding single acknowledged digit codes.
// Define DEC_SCHED_FIXED_PRIO_EN for highest-digit-wins arbitration.
module dec_req_scheduler #(
  parameter int N_REQ = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] i_d,
  input  logic             i_ack,
  output logic             o_valid,
  output logic [3:0]       o_b,
  output logic [N_REQ-1:0] o_pending
);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [N_REQ-1:0] r_d_q;
  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] w_rise;
  logic [N_REQ-1:0] w_clr;
  logic             r_valid;
  logic             w_valid_nx;
  logic [3:0]       r_b;
  logic [3:0]       w_b_nx;
  logic [3:0]       w_idx;

`ifdef DEC_SCHED_FIXED_PRIO_EN
  function automatic logic [3:0] fp_pick(
    input logic [N_REQ-1:0] p
  );
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++)
      if (p[i]) r = 4'(i);
    return r;
  endfunction

  assign w_idx = fp_pick(r_pending);
`else
  logic [3:0] r_ptr;
  logic [3:0] w_ptr_nx;

  // Search starts just past the last winner and wraps.
  function automatic logic [3:0] rr_pick(
    input logic [N_REQ-1:0] p,
    input logic [3:0]       ptr
  );
    logic [4:0] k;
    logic [3:0] r;
    logic       f;
    r = '0;
    f = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = 5'(ptr) + 5'd1 + 5'(i);
      if (k >= 5'(N_REQ)) k = k - 5'(N_REQ);
      for (int j = 0; j < N_REQ; j++)
        if (!f && k == 5'(j) && p[j]) begin
          f = 1'b1;
          r = 4'(j);
        end
    end
    return r;
  endfunction

  assign w_idx = rr_pick(r_pending, r_ptr);
`endif

  assign w_rise = i_d & ~r_d_q;

  always_comb begin
    w_state_nx = r_state;
    w_valid_nx = r_valid;
    w_b_nx     = r_b;
    w_clr      = '0;
`ifndef DEC_SCHED_FIXED_PRIO_EN
    w_ptr_nx   = r_ptr;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_state_nx = S_HOLD;
          w_valid_nx = 1'b1;
          w_b_nx     = w_idx + 4'd1;
          w_clr      = N_REQ'(1) << w_idx;
`ifndef DEC_SCHED_FIXED_PRIO_EN
          w_ptr_nx   = w_idx;
`endif
        end else begin
          w_valid_nx = 1'b0;
          w_b_nx     = '0;
        end
      end
      S_HOLD: begin
        if (i_ack) begin
          w_state_nx = S_IDLE;
          w_valid_nx = 1'b0;
          w_b_nx     = '0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_b       <= '0;
      r_d_q     <= '0;
      r_pending <= '0;
`ifndef DEC_SCHED_FIXED_PRIO_EN
      r_ptr     <= 4'(N_REQ - 1);
`endif
    end else begin
      r_state   <= w_state_nx;
      r_valid   <= w_valid_nx;
      r_b       <= w_b_nx;
      r_d_q     <= i_d;
      // Set wins over clear so a fresh event is never dropped.
      r_pending <= (r_pending & ~w_clr) | w_rise;
`ifndef DEC_SCHED_FIXED_PRIO_EN
      r_ptr     <= w_ptr_nx;
`endif
    end
  end

  assign o_valid   = r_valid;
  assign o_b       = r_b;
  assign o_pending = r_pending;

endmodule

// File: tb/tb_dec_req_scheduler.sv
// Directed self-checking bench for dec_req_scheduler.
// Expected grant orders follow the arbitration mode selected at build time.
module tb_dec_req_scheduler;

  logic       clk;
  logic       rst_n;
  logic [6:0] i_d;
  logic       i_ack;
  logic       o_valid;
  logic [3:0] o_b;
  logic [6:0] o_pending;

  int n_checks;
  int n_fail;

  dec_req_scheduler #(.N_REQ(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_d       (i_d),
    .i_ack     (i_ack),
    .o_valid   (o_valid),
    .o_b       (o_b),
    .o_pending (o_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_d   = '0;
    i_ack = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!o_valid && k < 8) begin
      step();
      k++;
    end
    n_checks++;
    if (o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: o_valid=%b required 1", tag, o_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_d   = 7'h00;
    i_ack = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b required 0", o_valid);
    end
    n_checks++;
    if (o_b !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_b: got %0d required 0", o_b);
    end
    n_checks++;
    if (o_pending !== 7'h00) begin
      n_fail++;
      $display("FAIL reset_pending: got %h required 00", o_pending);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (o_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_nogrant: got %b required 0", o_valid);
      end
    end
  endtask

  task automatic test_single();
    i_ack = 1'b1;
    i_d   = 7'b0000001;
    step();
    i_d = 7'h00;
    n_checks++;
    if (o_pending !== 7'h01 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pend: pend=%h valid=%b required 01/0",
               o_pending, o_valid);
    end
    step();
    n_checks++;
    if (o_valid !== 1'b1 || o_b !== 4'd1) begin
      n_fail++;
      $display("FAIL single_grant: valid=%b b=%0d required 1/1",
               o_valid, o_b);
    end
    n_checks++;
    if (o_pending !== 7'h00) begin
      n_fail++;
      $display("FAIL single_clr: got %h required 00", o_pending);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (o_valid !== 1'b0 || o_b !== 4'd0) begin
        n_fail++;
        $display("FAIL single_once: valid=%b b=%0d required 0/0",
                 o_valid, o_b);
      end
    end
    i_ack = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_b [3];
`ifdef DEC_SCHED_FIXED_PRIO_EN
    exp_b = '{4'd7, 4'd5, 4'd3};
`else
    exp_b = '{4'd3, 4'd5, 4'd7};
`endif
    i_ack = 1'b0;
    i_d   = 7'b1010100;
    step();
    i_d = 7'h00;
    n_checks++;
    if (o_pending !== 7'b1010100) begin
      n_fail++;
      $display("FAIL simul_pend: got %b required 1010100", o_pending);
    end
    for (int g = 0; g < 3; g++) begin
      wait_valid("simul_wait");
      n_checks++;
      if (o_b !== exp_b[g]) begin
        n_fail++;
        $display("FAIL simul_order[%0d]: got %0d required %0d",
                 g, o_b, exp_b[g]);
      end
      step();
      step();
      n_checks++;
      if (o_valid !== 1'b1 || o_b !== exp_b[g]) begin
        n_fail++;
        $display("FAIL simul_hold[%0d]: valid=%b b=%0d required 1/%0d",
                 g, o_valid, o_b, exp_b[g]);
      end
      i_ack = 1'b1;
      step();
      i_ack = 1'b0;
      n_checks++;
      if (o_valid !== 1'b0 || o_b !== 4'd0) begin
        n_fail++;
        $display("FAIL simul_gap[%0d]: valid=%b b=%0d required 0/0",
                 g, o_valid, o_b);
      end
    end
    step();
    n_checks++;
    if (o_valid !== 1'b0 || o_pending !== 7'h00) begin
      n_fail++;
      $display("FAIL simul_done: valid=%b pend=%h required 0/00",
               o_valid, o_pending);
    end
  endtask

  task automatic test_stall();
    i_ack = 1'b0;
    i_d   = 7'b0010000;
    step();
    wait_valid("stall_wait");
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (o_valid !== 1'b1 || o_b !== 4'd5) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b b=%0d required 1/5",
                 i, o_valid, o_b);
      end
      step();
    end
    i_ack = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (o_valid !== 1'b0 || o_pending !== 7'h00) begin
        n_fail++;
        $display("FAIL stall_retrig[%0d]: valid=%b pend=%h required 0/00",
                 i, o_valid, o_pending);
      end
      step();
    end
    i_d   = 7'h00;
    i_ack = 1'b0;
    step();
  endtask

  task automatic test_fairness();
    logic [3:0] exp_b [4];
`ifdef DEC_SCHED_FIXED_PRIO_EN
    exp_b = '{4'd6, 4'd6, 4'd6, 4'd6};
`else
    exp_b = '{4'd2, 4'd6, 4'd2, 4'd6};
`endif
    do_reset();
    i_ack = 1'b1;
    i_d   = 7'b0100010;
    step();
    i_d = 7'h00;
    for (int g = 0; g < 4; g++) begin
      wait_valid("fair_wait");
      n_checks++;
      if (o_b !== exp_b[g]) begin
        n_fail++;
        $display("FAIL fair_order[%0d]: got %0d required %0d",
                 g, o_b, exp_b[g]);
      end
      i_d = 7'b0100010;
      step();
      i_d = 7'h00;
      n_checks++;
      if (o_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fair_gap[%0d]: got %b required 0", g, o_valid);
      end
    end
    i_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_ack = 1'b0;
    i_d   = 7'b0001000;
    step();
    i_d = 7'h00;
    wait_valid("mid_wait");
    n_checks++;
    if (o_b !== 4'd4) begin
      n_fail++;
      $display("FAIL mid_grant: got %0d required 4", o_b);
    end
    i_d = 7'b0000001;
    step();
    i_d = 7'h00;
    n_checks++;
    if (o_pending !== 7'h01 || o_valid !== 1'b1 || o_b !== 4'd4) begin
      n_fail++;
      $display("FAIL mid_setup: pend=%h valid=%b b=%0d required 01/1/4",
               o_pending, o_valid, o_b);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if (o_valid !== 1'b0 || o_b !== 4'd0 || o_pending !== 7'h00) begin
      n_fail++;
      $display("FAIL mid_clear: valid=%b b=%0d pend=%h required 0/0/00",
               o_valid, o_b, o_pending);
    end
    i_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (o_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_nogrant[%0d]: got %b required 0", i, o_valid);
      end
    end
    i_ack = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    i_d      = '0;
    i_ack    = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_stall();
    test_fairness();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
